switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
//  Separable input-first switch allocator; one instance per router, directly downstream of the per-VC input buffers.
//  Each cycle it picks at most one VC per input port and at most one input port per output port.
//  It issues read commands to the winning buffers and crossbar selects to the switch traversal stage.
//  Fairness comes from registered round-robin priority pointers, updated iSLIP-style on successful grants only.
// PARAMETERS
//  PORT_NUM  5               number of router ports (input = output count), from noc_params
//  VC_NUM    2               virtual channels per port, from noc_params
//  VC_SIZE   $clog2(VC_NUM)  VC identifier width, from noc_params
// PORTS
//  clk              in   1                     rising-edge clock
//  rst              in   1                     synchronous, active-high reset
//  sa_ready_i       in   [PORT_NUM][VC_NUM]    buffer is in SA state and not empty
//  out_port_i       in   port_t [PORT_NUM][VC_NUM]   stored next-hop port per input VC
//  downstream_vc_i  in   [PORT_NUM][VC_NUM][VC_SIZE] allocated downstream VC per input VC
//  on_off_i         in   [PORT_NUM][VC_NUM]    per output port, per downstream VC: 1 = may send
//  read_o           out  [PORT_NUM][VC_NUM]    one-hot-or-zero read command per input port
//  in_vc_sel_o      out  [PORT_NUM][VC_SIZE]   winning VC at each input port (valid when read asserted)
//  xb_sel_o         out  port_t [PORT_NUM]     input port driving each output port
//  valid_o          out  [PORT_NUM]            output port carries a flit this cycle
// BEHAVIOUR
//  - Eligibility: req[i][v] = sa_ready_i[i][v] & on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]].
//  - Stage 1, per input i: round-robin over req[i][*] starting at in_ptr[i]; winner w1[i]; target t[i] = out_port_i[i][w1[i]].
//  - Stage 2, per output o: round-robin over {i : stage 1 had a winner and t[i]==o}, starting at out_ptr[o]; winner w2[o].
//  - Grants are combinational from current inputs. Latency is zero: read_o is valid in the same cycle as the request.
//  - read_o[i][w1[i]] = 1 only when w2[t[i]] == i. All other read bits are 0. At most one bit set per input and per output.
//  - Output o with a winner: valid_o[o] = 1, xb_sel_o[o] = w2[o]. With no winner: valid_o[o] = 0, xb_sel_o[o] = LOCAL.
//  - in_vc_sel_o[i] = w1[i] when the input wins stage 2, else 0.
//  - Pointer update on posedge clk, only for a full grant (input i wins output o):
//    in_ptr[i] <= (w1[i]+1) mod VC_NUM and out_ptr[o] <= (w2[o]+1) mod PORT_NUM.
//  - A stage-1 winner that loses stage 2 leaves both pointers unchanged, so it keeps priority and cannot starve.
//  - Wrap-around: pointer at the last index advances to 0.
//  - Invariants: an output never grants two inputs; a flit is never granted with on_off low (no-credit block).
//  - Inputs must not change combinationally on read_o within a cycle; the input buffers consume read_o at the next edge.
//  - Reset (rst=1 at posedge): all in_ptr, out_ptr <= 0. Outputs are combinational; while rst is high read_o = 0, valid_o = 0,
//    xb_sel_o = LOCAL, in_vc_sel_o = 0. Reset mid-operation drops any grant in that cycle; no state survives.
//  - No requests: all outputs at the reset values; pointers hold.
// STRUCTURE
//  - noc_params package: port_t enum {LOCAL,NORTH,SOUTH,WEST,EAST}, PORT_NUM, VC_NUM, VC_SIZE.
//  - Sub-module round_robin_arbiter #(AGENTS_NUM): inputs requests, priority pointer, update_en;
//    outputs one-hot grant, grant index, any-grant flag; owns its registered pointer and synchronous rst.
//  - Instances: PORT_NUM arbiters with AGENTS_NUM=VC_NUM for stage 1; PORT_NUM arbiters with AGENTS_NUM=PORT_NUM for stage 2.
//    update_en is driven from the full-grant condition.
// TESTING
//  1 Reset then idle: rst=1 for 2 cycles, all inputs 0
//    -> read_o=0, valid_o=0, xb_sel_o=LOCAL; next grant starts from index 0.
//  2 Single request: sa_ready_i[NORTH][1]=1, out_port=EAST, dvc=0, on_off[EAST][0]=1
//    -> read_o[NORTH]=2'b10, xb_sel_o[EAST]=NORTH, valid_o[EAST]=1, in_vc_sel_o[NORTH]=1.
//  3 Output contention: LOCAL, NORTH, SOUTH all request WEST, held for 3 cycles
//    -> WEST granted to LOCAL, then NORTH, then SOUTH; no cycle with more than one read toward WEST.
//  4 Credit block: as test 2 but on_off[EAST][0]=0 -> no grant; raise on_off -> grant in that same cycle.
//  5 VC fairness: NORTH VC0 and VC1 both ready, different free outputs, 4 cycles
//    -> grants alternate VC0, VC1, VC0, VC1.
//  6 Stage-2 loser keeps priority: NORTH VC0 loses EAST to LOCAL while NORTH VC1 also ready
//    -> next cycle NORTH still offers VC0; with out_ptr[EAST] past LOCAL, NORTH VC0 wins.
//    Also: rst asserted mid-stream -> same-cycle read_o=0 and pointers at 0 afterwards.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Router-wide NoC parameters and the port identifier type shared by the
// allocator and its testbench.
package noc_params;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = $clog2(VC_NUM);

endpackage

// File: rtl/switch_allocator_rr.sv
// Round-robin arbiter with its own registered priority pointer; the pointer
// moves past the winner only when the caller confirms the grant was used.
module round_robin_arbiter #(
  parameter int AGENTS_NUM = 2,
  localparam int IDX_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AGENTS_NUM-1:0] requests,
  input  logic                  update_en,
  output logic [AGENTS_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  any_grant
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Scan starting at the pointer, first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < AGENTS_NUM; k++) begin
      cand     = (int'(ptr) + k) % AGENTS_NUM;
      cand_idx = IDX_W'(cand);
      if (!any_grant && requests[cand_idx]) begin
        any_grant       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (update_en && any_grant)
      ptr <= (grant_idx == IDX_W'(AGENTS_NUM - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration followed by
// per-output input arbitration, with pointers advancing only on full grants.
module switch_allocator
  import noc_params::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           sa_ready_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]           out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           on_off_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]           read_o,
  output logic  [PORT_NUM-1:0][VC_SIZE-1:0]          in_vc_sel_o,
  output port_t [PORT_NUM-1:0]                       xb_sel_o,
  output logic  [PORT_NUM-1:0]                       valid_o
);

  localparam int PORT_W = $bits(port_t);

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_req;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]  w1;
  logic  [PORT_NUM-1:0]               s1_any;
  logic  [PORT_NUM-1:0]               in_win;
  port_t [PORT_NUM-1:0]               target;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;
  logic  [PORT_NUM-1:0][PORT_W-1:0]   w2;
  logic  [PORT_NUM-1:0]               s2_any;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
    // A VC is eligible only if its downstream VC has credit; reset masks all.
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign s1_req[i][v] = !rst && sa_ready_i[i][v]
                            && on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
    end

    round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_vc_arb (
      .clk       (clk),
      .rst       (rst),
      .requests  (s1_req[i]),
      .update_en (in_win[i]),
      .grant     (s1_grant[i]),
      .grant_idx (w1[i]),
      .any_grant (s1_any[i])
    );

    assign target[i]      = out_port_i[i][w1[i]];
    assign in_win[i]      = s1_any[i] && s2_any[target[i]] && (w2[target[i]] == PORT_W'(i));
    assign read_o[i]      = in_win[i] ? s1_grant[i] : '0;
    assign in_vc_sel_o[i] = in_win[i] ? w1[i] : '0;
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_req
      assign s2_req[o][i] = s1_any[i] && (target[i] == port_t'(o));
    end

    // Every stage-2 winner is by construction a full grant.
    round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_port_arb (
      .clk       (clk),
      .rst       (rst),
      .requests  (s2_req[o]),
      .update_en (s2_any[o]),
      .grant     (s2_grant[o]),
      .grant_idx (w2[o]),
      .any_grant (s2_any[o])
    );

    assign valid_o[o]  = s2_any[o];
    assign xb_sel_o[o] = s2_any[o] ? port_t'(w2[o]) : LOCAL;
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator; expected values are
// hand-derived from the round-robin pointer history of each scenario.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              sa_ready;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              read;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]             in_vc_sel;
  port_t [PORT_NUM-1:0]                          xb_sel;
  logic  [PORT_NUM-1:0]                          valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .sa_ready_i      (sa_ready),
    .out_port_i      (out_port),
    .downstream_vc_i (dvc),
    .on_off_i        (on_off),
    .read_o          (read),
    .in_vc_sel_o     (in_vc_sel),
    .xb_sel_o        (xb_sel),
    .valid_o         (valid)
  );

  task automatic clear_inputs();
    sa_ready = '0;
    dvc      = '0;
    on_off   = '0;
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        out_port[i][v] = LOCAL;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [PORT_NUM-1:0][VC_NUM-1:0] exp_read;
    exp_read = '0;
    rst = 1'b1;
    clear_inputs();
    sa_ready[NORTH][1] = 1'b1;
    out_port[NORTH][1] = EAST;
    on_off[EAST][0]    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (read !== exp_read || valid !== 5'b0 || in_vc_sel !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc%0d: read=%b valid=%b vcsel=%b, want all zero", c, read, valid, in_vc_sel);
      end
      checks++;
      if (xb_sel !== {PORT_NUM{LOCAL}}) begin
        errors++;
        $display("[TB] FAIL reset_xb cyc%0d: xb_sel=%h want all LOCAL", c, xb_sel);
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (read !== exp_read || valid !== 5'b0 || xb_sel !== {PORT_NUM{LOCAL}}) begin
      errors++;
      $display("[TB] FAIL idle: read=%b valid=%b xb=%h want zeros", read, valid, xb_sel);
    end
    next_cycle();
  endtask

  task automatic test_single_request();
    clear_inputs();
    sa_ready[NORTH][1] = 1'b1;
    out_port[NORTH][1] = EAST;
    on_off[EAST][0]    = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 10'b00_00_00_10_00) begin
      errors++;
      $display("[TB] FAIL single_read: read=%b want %b", read, 10'b00_00_00_10_00);
    end
    checks++;
    if (xb_sel[EAST] !== NORTH || valid !== 5'b10000 || in_vc_sel[NORTH] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_xb: xb[E]=%0d valid=%b vcsel[N]=%b want 1 10000 1", xb_sel[EAST], valid, in_vc_sel[NORTH]);
    end
    next_cycle();
  endtask

  task automatic test_output_contention();
    port_t exp_win [3] = '{LOCAL, NORTH, SOUTH};
    logic [PORT_NUM-1:0][VC_NUM-1:0] exp_read;
    clear_inputs();
    on_off[WEST][0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sa_ready[i][0] = 1'b1;
      out_port[i][0] = WEST;
    end
    for (int c = 0; c < 3; c++) begin
      exp_read = '0;
      exp_read[exp_win[c]] = 2'b01;
      @(negedge clk);
      checks++;
      if (read !== exp_read || xb_sel[WEST] !== exp_win[c] || valid !== 5'b01000) begin
        errors++;
        $display("[TB] FAIL contention cyc%0d: read=%b xb[W]=%0d valid=%b want %b %0d 01000",
                 c, read, xb_sel[WEST], valid, exp_read, exp_win[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_credit_block();
    clear_inputs();
    sa_ready[NORTH][1] = 1'b1;
    out_port[NORTH][1] = EAST;
    on_off[EAST][1]    = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== '0 || valid !== 5'b0) begin
      errors++;
      $display("[TB] FAIL credit_blocked: read=%b valid=%b want zeros", read, valid);
    end
    on_off[EAST][0] = 1'b1;
    #1;
    checks++;
    if (read[NORTH] !== 2'b10 || xb_sel[EAST] !== NORTH || valid !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL credit_release: read[N]=%b xb[E]=%0d valid=%b want 10 1 10000", read[NORTH], xb_sel[EAST], valid);
    end
    next_cycle();
  endtask

  task automatic test_vc_fairness();
    logic [VC_NUM-1:0] exp_rd;
    clear_inputs();
    sa_ready[NORTH]    = 2'b11;
    out_port[NORTH][0] = EAST;
    out_port[NORTH][1] = SOUTH;
    on_off[EAST][0]    = 1'b1;
    on_off[SOUTH][0]   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_rd = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if (read[NORTH] !== exp_rd || in_vc_sel[NORTH] !== VC_SIZE'(c % 2)
          || valid !== ((c % 2 == 0) ? 5'b10000 : 5'b00100)) begin
        errors++;
        $display("[TB] FAIL vc_fair cyc%0d: read[N]=%b vcsel=%b valid=%b want %b %0d", c, read[NORTH], in_vc_sel[NORTH], valid, exp_rd, c % 2);
      end
      next_cycle();
    end
  endtask

  task automatic test_loser_priority();
    clear_inputs();
    sa_ready[LOCAL][0] = 1'b1;
    out_port[LOCAL][0] = EAST;
    sa_ready[NORTH]    = 2'b11;
    out_port[NORTH][0] = EAST;
    out_port[NORTH][1] = WEST;
    on_off[EAST][0]    = 1'b1;
    on_off[WEST][0]    = 1'b1;
    @(negedge clk);
    checks++;
    if (read !== 10'b00_00_00_00_01 || xb_sel[EAST] !== LOCAL || valid !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL loser_cyc0: read=%b xb[E]=%0d valid=%b want 0000000001 0 10000", read, xb_sel[EAST], valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (read !== 10'b00_00_00_01_00 || xb_sel[EAST] !== NORTH || in_vc_sel[NORTH] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loser_cyc1: read=%b xb[E]=%0d vcsel[N]=%b want 0000000100 1 0", read, xb_sel[EAST], in_vc_sel[NORTH]);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (read !== '0 || valid !== 5'b0 || xb_sel !== {PORT_NUM{LOCAL}}) begin
      errors++;
      $display("[TB] FAIL mid_reset: read=%b valid=%b xb=%h want zeros", read, valid, xb_sel);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (read !== 10'b00_00_00_00_01 || xb_sel[EAST] !== LOCAL || valid !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL post_reset_ptrs: read=%b xb[E]=%0d valid=%b want 0000000001 0 10000", read, xb_sel[EAST], valid);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    test_reset();
    test_single_request();
    test_output_contention();
    test_credit_block();
    test_vc_fairness();
    test_loser_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
